// File: rtl/seq_divider.sv
// Sequential unsigned divider: DW-bit dividend by VW-bit divisor, restoring
// shift-subtract, one quotient bit per clock with a start/busy/done handshake.
module seq_divider #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW:0]   rem_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;

  // One restoring step: bring in the next dividend bit, try to subtract the
  // divisor; the extra MSB of trial is the borrow that says "restore".
  logic [VW:0]   shifted;
  logic [VW+1:0] trial;
  logic          neg;
  logic [VW:0]   rem_next;
  logic [DW-1:0] dvd_next;

  always_comb begin
    shifted  = {rem_q[VW-1:0], dvd_q[DW-1]};
    trial    = {1'b0, shifted} - {2'b00, dvs_q};
    neg      = trial[VW+1];
    rem_next = neg ? shifted : trial[VW:0];
    dvd_next = {dvd_q[DW-2:0], ~neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_q <= a;
            dvs_q <= b;
            rem_q <= '0;
            cnt   <= '0;
            if (b == '0) begin
              // No iterations: publish the saturated result straight away.
              quotient  <= '1;
              remainder <= a[VW-1:0];
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= dvd_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(DW-1)) begin
            // Remainder is always < divisor, so the top bit is zero here.
            quotient  <= dvd_next;
            remainder <= rem_next[VW-1:0];
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, arithmetic,
// divide-by-zero, ignored/held start and asynchronous reset abort.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [15:0] b;
  logic        busy, done, dbz;
  logic [31:0] quotient;
  logic [15:0] remainder;

  int checks = 0;
  int fails  = 0;
  int n, nb, n2;

  seq_divider #(.DW(32), .VW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands and start before an edge; returns just after the accepting edge.
  task automatic launch(input logic [31:0] av, input logic [15:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (done) break;
    end
    if (!done) check("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] av, input logic [15:0] bv,
                    input logic [31:0] eq, input logic [15:0] er, input logic ed,
                    input int elat, input int ebusy);
    int c, bc;
    launch(av, bv);
    wait_done(c, bc);
    check({tag, "_lat"}, c, elat);
    check({tag, "_busy_cycles"}, bc, ebusy);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, ed});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", {16'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // done seen on the 33rd falling edge after the accepting edge; busy for 32.
    op("basic",  32'd272,     16'd16,    32'd17,         16'd0,    1'b0, 33, 32);
    op("rt1",    32'd757968,  16'd845,   32'd897,        16'd3,    1'b0, 33, 32);
    op("rt2",    32'd3904000, 16'd1952,  32'd2000,       16'd0,    1'b0, 33, 32);
    op("max_b1", 32'hFFFFFFFF,16'd1,     32'hFFFFFFFF,   16'd0,    1'b0, 33, 32);
    op("zero_a", 32'd0,       16'd5,     32'd0,          16'd0,    1'b0, 33, 32);
    op("big_b",  32'd13,      16'd65535, 32'd0,          16'd13,   1'b0, 33, 32);
    op("dbz",    32'd460800,  16'd0,     32'hFFFFFFFF,   16'h0800, 1'b1, 1,  0);
    op("after_dbz", 32'd100,  16'd7,     32'd14,         16'd2,    1'b0, 33, 32);

    // start pulsed mid-CALC with other operands is ignored; outputs hold.
    launch(32'd1000000, 16'd1000);
    repeat (9) @(negedge clk);
    check("hold_q_calc", quotient, 32'd14);
    check("hold_r_calc", {16'd0, remainder}, 32'd2);
    a = 32'd5; b = 16'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n2, nb);
    check("ign_lat", 9 + n2, 33);
    check("ign_q", quotient, 32'd1000);
    check("ign_r", {16'd0, remainder}, 32'd0);
    check("ign_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);

    // start held: next acceptance right after DONE, 34-cycle period.
    a = 32'd100; b = 16'd7; start = 1'b1;
    wait_done(n, nb);
    check("held1_q", quotient, 32'd14);
    a = 32'd1000; b = 16'd3;
    wait_done(n, nb);
    start = 1'b0;
    check("held_period", n, 34);
    check("held2_q", quotient, 32'd333);
    check("held2_r", {16'd0, remainder}, 32'd1);
    repeat (3) @(negedge clk);
    check("held_stop_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    launch(32'd272, 16'd16);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_q", quotient, 32'd0);
    check("arst_r", {16'd0, remainder}, 32'd0);
    check("arst_dbz", {31'd0, dbz}, 32'd0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n++;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) n++;
    end
    check("arst_no_done", n, 0);
    op("post_rst", 32'd3777200, 16'd1900, 32'd1988, 16'd0, 1'b0, 33, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
